// File: rtl/mem_copy_engine_pkg.sv
// Shared widths and FSM encoding for the memory copy/fill engine.
package mem_copy_engine_pkg;

    localparam int DEF_DATA_WIDTH = 20;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_LEN_WIDTH  = DEF_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILLW = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Data-port bus between the copy engine (master) and main memory (slave).
interface mem_copy_engine_if
    import mem_copy_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_wr_en, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_wr_en, output mem_rdata);
endinterface

// File: rtl/mem_copy_engine.sv
// Word-sequential copy / constant-fill initiator for the main memory data port.
// All memory-side outputs are registered so they are stable at the memory's negedge write.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_done,
    mem_copy_engine_if.master     mem
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] src_ptr_reg, src_ptr_next;
    logic [ADDR_WIDTH-1:0] dst_ptr_reg, dst_ptr_next;
    logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
    logic [LEN_WIDTH-1:0]  words_done_reg, words_done_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [LEN_WIDTH-1:0]  len_eff;

    assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            src_ptr_reg    <= '0;
            dst_ptr_reg    <= '0;
            remaining_reg  <= '0;
            words_done_reg <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wr_en_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            src_ptr_reg    <= src_ptr_next;
            dst_ptr_reg    <= dst_ptr_next;
            remaining_reg  <= remaining_next;
            words_done_reg <= words_done_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wr_en_reg      <= wr_en_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        src_ptr_next    = src_ptr_reg;
        dst_ptr_next    = dst_ptr_reg;
        remaining_next  = remaining_reg;
        words_done_next = words_done_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wr_en_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    src_ptr_next    = src_addr;
                    dst_ptr_next    = dst_addr;
                    remaining_next  = len_eff;
                    words_done_next = '0;
                    if (len_eff == '0) begin
                        state_next = ST_DONE;
                    end else if (fill_mode) begin
                        state_next = ST_FILLW;
                        addr_next  = dst_addr;
                        wdata_next = fill_data;
                        wr_en_next = 1'b1;
                    end else begin
                        state_next = ST_READ;
                        addr_next  = src_addr;
                    end
                end
            end
            ST_READ: begin
                wdata_next = mem.mem_rdata;
                addr_next  = dst_ptr_reg;
                wr_en_next = 1'b1;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                src_ptr_next    = src_ptr_reg + 1'b1;
                dst_ptr_next    = dst_ptr_reg + 1'b1;
                words_done_next = words_done_reg + 1'b1;
                remaining_next  = remaining_reg - 1'b1;
                if (remaining_reg == LEN_WIDTH'(1)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_READ;
                    addr_next  = src_ptr_reg + 1'b1;
                end
            end
            ST_FILLW: begin
                // wdata_reg still holds the fill constant latched at start
                dst_ptr_next    = dst_ptr_reg + 1'b1;
                words_done_next = words_done_reg + 1'b1;
                remaining_next  = remaining_reg - 1'b1;
                if (remaining_reg == LEN_WIDTH'(1)) begin
                    state_next = ST_DONE;
                end else begin
                    addr_next  = dst_ptr_reg + 1'b1;
                    wr_en_next = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign words_done    = words_done_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign mem.mem_wr_en = wr_en_reg;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized scoreboard bench for mem_copy_engine against a 32x20 negedge-write memory.
module tb_mem_copy_engine;

    localparam time PERIOD = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        fill_mode;
    logic [4:0]  src_addr;
    logic [4:0]  dst_addr;
    logic [5:0]  len;
    logic [19:0] fill_data;
    logic        busy;
    logic        done;
    logic [5:0]  words_done;

    mem_copy_engine_if #(.DATA_WIDTH(20), .ADDR_WIDTH(5)) bus ();

    mem_copy_engine #(.DATA_WIDTH(20), .ADDR_WIDTH(5), .LEN_WIDTH(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fill_mode  (fill_mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem        (bus.master)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    // Memory model: combinational read, negedge write; bench preload port used only while idle.
    logic [19:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [19:0] pl_data;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(negedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_en)    mem[pl_addr]      <= pl_data;
    end

    typedef struct {
        time              t_acc;
        int               lat;
        int               n;
        logic             fm;
        int               src;
        int               dst;
        logic [31:0][19:0] img;
    } exp_t;

    exp_t              exp_q[$];
    logic [31:0][19:0] ref_mem;
    logic              mem_chk_req;
    int                checks;
    int                errors;
    int                txn_id;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic mem_cmp(input string name, input logic [31:0][19:0] expv);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int a = 0; a < 32; a++) begin
            if (mem[a] !== expv[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, first at [%0d] got %h expected %h",
                     name, bad, first, mem[first], expv[first]);
        end
    endtask

    int   wr_cnt;
    logic prev_done;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_busy", longint'(busy), 0);
            chk("rst_done", longint'(done), 0);
            chk("rst_words_done", longint'(words_done), 0);
            chk("rst_mem_addr", longint'(bus.mem_addr), 0);
            chk("rst_mem_wdata", longint'(bus.mem_wdata), 0);
            chk("rst_mem_wr_en", longint'(bus.mem_wr_en), 0);
            wr_cnt    = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_pulse_width", longint'(done), 0);
            prev_done = done;
            if (bus.mem_wr_en === 1'b1) wr_cnt++;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t   e;
                    longint lat;
                    e   = exp_q.pop_front();
                    lat = longint'(($time - e.t_acc - PERIOD / 2) / PERIOD) + 1;
                    txn_id++;
                    $display("txn %0d: %s src=%0d dst=%0d len=%0d latency=%0d words_done=%0d wr_cycles=%0d",
                             txn_id, e.fm ? "fill" : "copy", e.src, e.dst, e.n, lat, words_done, wr_cnt);
                    chk("latency", lat, longint'(e.lat));
                    chk("words_done", longint'(words_done), longint'(e.n));
                    chk("wr_en_cycles", longint'(wr_cnt), longint'(e.n));
                    chk("busy_at_done", longint'(busy), 1);
                    mem_cmp("mem_after_txn", e.img);
                end
                wr_cnt = 0;
            end
            if (mem_chk_req) begin
                chk("queue_empty", longint'(exp_q.size()), 0);
                mem_cmp("mem_snapshot", ref_mem);
            end
        end
    end

    // ---------------- reference model and driver ----------------
    task automatic model_apply(input logic fm, input int src, input int dst, input int n, input logic [19:0] fd);
        for (int i = 0; i < n; i++) begin
            ref_mem[(dst + i) % 32] = fm ? fd : ref_mem[(src + i) % 32];
        end
    endtask

    task automatic poke(input int a, input logic [19:0] d);
        @(posedge clk);
        #1;
        pl_en   = 1'b1;
        pl_addr = 5'(a);
        pl_data = d;
        @(negedge clk);
        #1;
        pl_en      = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic scramble_inputs();
        fill_mode = 1'($urandom);
        src_addr  = 5'($urandom);
        dst_addr  = 5'($urandom);
        len       = 6'($urandom);
        fill_data = 20'($urandom);
    endtask

    task automatic issue(input logic fm, input int src, input int dst, input int ln,
                         input logic [19:0] fd, input bit disturb);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        start     = 1'b1;
        fill_mode = fm;
        src_addr  = 5'(src);
        dst_addr  = 5'(dst);
        len       = 6'(ln);
        fill_data = fd;
        @(posedge clk);
        n       = (ln > 32) ? 32 : ln;
        e.t_acc = $time;
        e.n     = n;
        e.fm    = fm;
        e.src   = src;
        e.dst   = dst;
        e.lat   = (n == 0) ? 1 : (fm ? n + 1 : 2 * n + 1);
        model_apply(fm, src, dst, n, fd);
        e.img = ref_mem;
        exp_q.push_back(e);
        #1;
        start = 1'b0;
        scramble_inputs();
        if (disturb) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            scramble_inputs();
            len = 6'd2;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL done_timeout: got no done within 200 cycles, expected done");
            $fatal(1, "transfer never completed");
        end
        if (disturb) begin
            // start presented while in the DONE cycle must also be dropped
            start = 1'b1;
            scramble_inputs();
            len = 6'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic request_mem_check();
        @(posedge clk);
        #1;
        mem_chk_req = 1'b1;
        @(negedge clk);
        #1;
        mem_chk_req = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        txn_id      = 0;
        mem_chk_req = 1'b0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        start       = 1'b0;
        scramble_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) poke(a, 20'($urandom));

        // staged inputs moved to working locations
        poke(29, 20'd3); poke(30, 20'd4); poke(31, 20'd5);
        issue(1'b0, 29, 0, 3, 20'h0, 1'b0);
        issue(1'b0, 5, 7, 0, 20'h0, 1'b0);
        poke(30, 20'hAAAAA); poke(31, 20'hBBBBB); poke(0, 20'hCCCCC); poke(1, 20'hDDDDD);
        issue(1'b0, 30, 10, 4, 20'h0, 1'b0);
        issue(1'b1, 9, 31, 3, 20'hABCDE, 1'b0);
        issue(1'b0, 3, 16, 5, 20'h0, 1'b1);
        issue(1'b0, 4, 5, 6, 20'h0, 1'b0);
        issue(1'b1, 0, 7, 45, 20'h12345, 1'b0);
        for (int a = 0; a < 32; a++) poke(a, 20'($urandom));
        issue(1'b0, 2, 17, 63, 20'h0, 1'b0);
        issue(1'b1, 0, 12, 1, 20'h55555, 1'b0);
        request_mem_check();

        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 40)), 20'($urandom), 1'b0);
        end
        request_mem_check();

        // reset after the second write commits: two words land, nothing more
        for (int a = 0; a < 32; a++) poke(a, 20'($urandom));
        @(negedge clk);
        start     = 1'b1;
        fill_mode = 1'b0;
        src_addr  = 5'd20;
        dst_addr  = 5'd8;
        len       = 6'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_apply(1'b0, 20, 8, 2, 20'h0);
        repeat (3) @(posedge clk);
        #7 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        request_mem_check();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
